// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit FIFO and launcher in front of uart_tx.
// Queues processor writes and hands one word at a time to the serializer.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_BITS-1:0]  wr_data,
    input  logic                  flush,
    input  logic                  clr_ovf,
    input  logic                  tx_en,
    input  logic                  tx_done,
    output logic                  tx_start,
    output logic [DATA_BITS-1:0]  tx_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  busy,
    output logic                  overflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DATA_BITS-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [DATA_BITS-1:0]  tx_data_q, tx_data_d;
    logic                  ovf_q, ovf_d;

    logic wr_acc;
    logic pop;

    // Status flags come straight from the registered level.
    assign full  = (level_q == DEPTH_L);
    assign empty = (level_q == '0);
    assign level = level_q;

    // A flush cycle neither stores nor launches.
    assign wr_acc = wr_en & ~full & ~flush;
    assign pop    = (state_q == IDLE) & tx_en & ~empty & ~flush;

    // Storage array; contents need no reset since level gates reads.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointer, level, overflow and output-word next-state logic.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        tx_data_d = tx_data_q;
        ovf_d     = ovf_q;

        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        // Setting takes priority over clearing in the same cycle.
        if (wr_en & full & ~flush) begin
            ovf_d = 1'b1;
        end

        if (pop) begin
            tx_data_d = mem[rd_ptr_q];
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            end
            unique case ({wr_acc, pop})
                2'b10:   level_d = level_q + (ADDR_WIDTH + 1)'(1);
                2'b01:   level_d = level_q - (ADDR_WIDTH + 1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            tx_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            tx_data_q <= tx_data_d;
            ovf_q     <= ovf_d;
        end
    end

    // Launcher state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Launcher next state; tx_done only matters while waiting.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (pop) state_d = LAUNCH;
            LAUNCH:    state_d = WAIT_DONE;
            WAIT_DONE: if (tx_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Launcher outputs (Moore).
    always_comb begin
        tx_start = (state_q == LAUNCH);
        busy     = (state_q != IDLE);
    end

    assign tx_data  = tx_data_q;
    assign overflow = ovf_q;

endmodule
